// File: rtl/alu_result_stage_if.sv
// rtl/alu_result_stage_if.sv - ALU result stream bundle: producer-side inputs and consumer-side outputs
interface alu_result_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_overflow;
    logic        in_zero;
    logic        in_negative;
    logic [2:0]  in_control;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_zero;
    logic        out_negative;

    modport slave (
        input  in_valid, in_result, in_overflow, in_zero, in_negative, in_control, out_ready,
        output in_ready, out_valid, out_result, out_overflow, out_zero, out_negative
    );

    modport master (
        output in_valid, in_result, in_overflow, in_zero, in_negative, in_control, out_ready,
        input  in_ready, out_valid, out_result, out_overflow, out_zero, out_negative
    );
endinterface

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - 2-entry registered ALU result buffer with overflow masking, sticky overflow and accept counter
module alu_result_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_result_stage_if.slave bus,
    input  logic             sticky_clear,
    output logic             sticky_ovf,
    output logic [CNT_W-1:0] accepted_cnt
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0][31:0] r_result;
    logic [1:0]       r_ovf;
    logic [1:0]       r_zero;
    logic [1:0]       r_neg;
    logic             r_sticky;
    logic [CNT_W-1:0] r_cnt;

    logic w_push;
    logic w_pop;
    logic w_arith;
    logic w_ovf_masked;

    // Ready looks only at registered state so the consumer can never stall the producer combinationally.
    assign bus.in_ready  = (r_state != FULL);
    assign bus.out_valid = (r_state != EMPTY);

    assign w_push       = bus.in_valid & bus.in_ready;
    assign w_pop        = bus.out_valid & bus.out_ready;
    assign w_arith      = (bus.in_control == 3'h2) || (bus.in_control == 3'h3);
    assign w_ovf_masked = bus.in_overflow & w_arith;

    assign bus.out_result   = r_result[r_rd_ptr];
    assign bus.out_overflow = r_ovf[r_rd_ptr];
    assign bus.out_zero     = r_zero[r_rd_ptr];
    assign bus.out_negative = r_neg[r_rd_ptr];

    assign sticky_ovf   = r_sticky;
    assign accepted_cnt = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= EMPTY;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_result <= '0;
            r_ovf    <= '0;
            r_zero   <= '0;
            r_neg    <= '0;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                EMPTY:   if (w_push) r_state <= ONE;
                ONE: begin
                    if (w_push && !w_pop)      r_state <= FULL;
                    else if (w_pop && !w_push) r_state <= EMPTY;
                end
                FULL:    if (w_pop) r_state <= ONE;
                default: r_state <= EMPTY;
            endcase

            if (w_push) begin
                r_result[r_wr_ptr] <= bus.in_result;
                r_ovf[r_wr_ptr]    <= w_ovf_masked;
                r_zero[r_wr_ptr]   <= bus.in_zero;
                r_neg[r_wr_ptr]    <= bus.in_negative;
                r_wr_ptr           <= ~r_wr_ptr;
                r_cnt              <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end

            // A new overflow in the same cycle as a clear must not be lost.
            if (w_push && w_ovf_masked) begin
                r_sticky <= 1'b1;
            end else if (sticky_clear) begin
                r_sticky <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - directed and randomized checks of alu_result_stage against a queue model
module tb_alu_result_stage;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sticky_clear = 1'b0;
    logic             sticky_ovf;
    logic [CNT_W-1:0] accepted_cnt;

    alu_result_stage_if bus ();

    alu_result_stage #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .sticky_clear (sticky_clear),
        .sticky_ovf   (sticky_ovf),
        .accepted_cnt (accepted_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r;
        logic        o;
        logic        z;
        logic        n;
    } ent_t;

    ent_t q[$];
    int   m_cnt    = 0;
    logic m_sticky = 1'b0;
    int   checks   = 0;
    int   errors   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_result", bus.out_result, q[0].r);
            chk("out_overflow", 32'(bus.out_overflow), 32'(q[0].o));
            chk("out_zero", 32'(bus.out_zero), 32'(q[0].z));
            chk("out_negative", 32'(bus.out_negative), 32'(q[0].n));
        end
        chk("sticky_ovf", 32'(sticky_ovf), 32'(m_sticky));
        chk("accepted_cnt", 32'(accepted_cnt), 32'(m_cnt % (1 << CNT_W)));
    endtask

    task automatic step(input logic v, input logic [31:0] r, input logic o, input logic z,
                        input logic n, input logic [2:0] ctl, input logic ordy, input logic sclr);
        logic push;
        logic pop;
        logic mo;
        ent_t e;
        @(negedge clk);
        bus.in_valid    = v;
        bus.in_result   = r;
        bus.in_overflow = o;
        bus.in_zero     = z;
        bus.in_negative = n;
        bus.in_control  = ctl;
        bus.out_ready   = ordy;
        sticky_clear    = sclr;
        #1;
        check_outputs();
        push = v && (q.size() < 2);
        pop  = ordy && (q.size() > 0);
        mo   = o && (ctl == 3'h2 || ctl == 3'h3);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (push) begin
            e.r = r; e.o = mo; e.z = z; e.n = n;
            q.push_back(e);
            m_cnt++;
        end
        if (push && mo) m_sticky = 1'b1;
        else if (sclr) m_sticky = 1'b0;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'h0, ordy, 1'b0);
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_result   = 32'h0;
        bus.in_overflow = 1'b0;
        bus.in_zero     = 1'b0;
        bus.in_negative = 1'b0;
        bus.in_control  = 3'h0;
        bus.out_ready   = 1'b0;

        // Reset
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
        chk("rst_out_result", bus.out_result, 32'h0);
        chk("rst_sticky", 32'(sticky_ovf), 32'h0);
        chk("rst_cnt", 32'(accepted_cnt), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("post_rst_out_result", bus.out_result, 32'h0);

        // Streaming
        step(1'b1, 32'h00000005, 1'b0, 1'b0, 1'b0, 3'h2, 1'b1, 1'b0);
        step(1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0, 3'h2, 1'b1, 1'b0);
        step(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 3'h2, 1'b1, 1'b0);
        idle(1'b1);
        chk("stream_cnt", 32'(accepted_cnt), 32'd3);

        // Backpressure: third offer must wait until the consumer drains.
        step(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 3'h2, 1'b0, 1'b0);
        step(1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 3'h2, 1'b0, 1'b0);
        step(1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 3'h2, 1'b0, 1'b0);
        chk("bp_head_held", bus.out_result, 32'h11);
        step(1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 3'h2, 1'b1, 1'b0);
        step(1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 3'h2, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Overflow masking and sticky
        step(1'b1, 32'h80000000, 1'b1, 1'b0, 1'b1, 3'h2, 1'b1, 1'b0);
        step(1'b1, 32'h0000F00F, 1'b1, 1'b0, 1'b0, 3'h7, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'h0, 1'b1, 1'b1);
        step(1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 3'h3, 1'b1, 1'b1);
        idle(1'b1);
        chk("sticky_set_wins", 32'(sticky_ovf), 32'h1);

        // Simultaneous push and pop with one entry buffered
        step(1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 3'h0, 1'b0, 1'b0);
        step(1'b1, 32'hAA, 1'b0, 1'b0, 1'b0, 3'h0, 1'b1, 1'b0);
        idle(1'b0);
        chk("pp_head", bus.out_result, 32'hAA);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom(), 1'($urandom()), 1'($urandom()),
                 1'($urandom()), 3'($urandom()), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 7) == 0));
        end

        // Mid-operation asynchronous reset while full
        step(1'b1, 32'h77, 1'b1, 1'b0, 1'b0, 3'h2, 1'b0, 1'b0);
        step(1'b1, 32'h78, 1'b0, 1'b0, 1'b0, 3'h2, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'h1);
        chk("mid_rst_cnt", 32'(accepted_cnt), 32'h0);
        chk("mid_rst_sticky", 32'(sticky_ovf), 32'h0);
        chk("mid_rst_out_result", bus.out_result, 32'h0);
        q.delete();
        m_cnt    = 0;
        m_sticky = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Counter wrap with 17 pushes
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 32'(i), 1'b0, 1'b0, 1'b0, 3'h0, 1'b1, 1'b0);
        end
        idle(1'b1);
        chk("wrap_cnt", 32'(accepted_cnt), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage directly downstream of the 32-bit ALU. It captures each ALU result and its overflow/zero/negative flags into a 2-entry buffer with valid/ready handshakes on both sides, so the consumer (writeback / branch logic) can stall without losing results. It masks overflow for logic operations, keeps a sticky overflow flag, and counts results accepted.

## Interface
Parameters:
- CNT_W, 16, width of the accepted-result counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ALU result presented this cycle
- in_ready  out  1  stage can accept an entry this cycle
- in_result  in  32  ALU out bus
- in_overflow  in  1  ALU overflow
- in_zero  in  1  ALU zero
- in_negative  in  1  ALU negative
- in_control  in  3  ALU control code that produced the result
- out_valid  out  1  head entry is valid
- out_ready  in  1  consumer takes the head entry this cycle
- out_result  out  32  head result
- out_overflow  out  1  head overflow (masked)
- out_zero  out  1  head zero
- out_negative  out  1  head negative
- sticky_ovf  out  1  set when any accepted arithmetic result overflowed
- sticky_clear  in  1  synchronous clear of sticky_ovf
- accepted_cnt  out  CNT_W  number of accepted entries, modulo 2^CNT_W

Clock and reset: one clock; reset is asynchronous and active-low.

## Operation
- Storage: 2 entries of {result[31:0], ovf, zero, neg}; 1-bit write pointer, 1-bit read pointer, 2-bit count (0..2).
- States: EMPTY (count 0), ONE (count 1), FULL (count 2).
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != 2); depends only on registered state, never on out_ready.
- out_valid = (count != 0); out_* driven from entry at read pointer.
- Transitions: EMPTY→ONE on push. ONE→FULL on push only; ONE→EMPTY on pop only; ONE stays ONE on push and pop together (head replaced by new entry). FULL→ONE on pop; push impossible in FULL.
- Overflow masking: stored ovf = in_overflow only when in_control is 3'h2 (ADD) or 3'h3 (SUB); otherwise 0. zero and negative are stored unmodified.
- sticky_ovf: set on a push whose masked ovf is 1; cleared when sticky_clear=1; set wins if both occur in the same cycle.
- accepted_cnt: +1 per push, wraps from 2^CNT_W−1 to 0.
- When not pushing, in_* are ignored. Entry contents are not read when out_valid=0.

## Timing
- Reset (rst_n low, asynchronous): count=0, both pointers 0, out_valid=0, in_ready=1, out_result=0, out_overflow=out_zero=out_negative=0, sticky_ovf=0, accepted_cnt=0. Storage entries cleared to 0.
- Latency: an entry pushed at edge N is on out_* with out_valid=1 from just after edge N; minimum 1 cycle.
- Throughput: 1 entry/cycle with out_ready held high; no bubbles.
- Consumer stalls: holding out_ready low keeps head data and flags stable until the pop.
- Reset asserted mid-operation discards all buffered entries; no partial state survives.
- sticky_ovf and accepted_cnt update on the same edge as the push.

## Test plan
- Reset: rst_n low, then high → out_valid=0, in_ready=1, sticky_ovf=0, accepted_cnt=0, out_result=0.
- Streaming: push ADD results 0x00000005, 0x00000000 (zero=1), 0xFFFFFFFF (neg=1) on consecutive cycles, out_ready=1 → same three appear in order one cycle later, flags unchanged, accepted_cnt=3.
- Backpressure: out_ready=0, push 0x11, 0x22 → in_ready=0 after 2nd push; 3rd offered value 0x33 not taken; out_result stays 0x11; raise out_ready → 0x11, 0x22, then 0x33 accepted and delivered, none lost or duplicated.
- Overflow masking: push control=3'h2 with overflow=1 → out_overflow=1, sticky_ovf=1; push control=3'h7 (XOR) with overflow=1 → out_overflow=0; sticky_clear alone → sticky_ovf=0; sticky_clear together with SUB overflow push → sticky_ovf=1.
- Simultaneous push/pop in ONE: hold count=1, push 0xAA while popping head 0x55 → 0x55 consumed, head becomes 0xAA, count remains 1.
- Wrap and mid-operation reset: with CNT_W=4, 17 pushes → accepted_cnt=1; assert rst_n low while FULL → out_valid=0, in_ready=1 immediately (asynchronous), accepted_cnt=0.
